// File: rtl/stg_pkg.sv
// Shared stage definitions: playfield bounds, boss FSM states, phase encoding
// and the small helpers the boss sequencer uses for phase and patrol speed.
package stg_pkg;

  localparam int unsigned COORD_W    = 10;
  localparam int unsigned HP_W       = 8;
  localparam int unsigned PHASE_W    = 2;
  localparam int unsigned PLAY_MAX_X = 384;
  localparam int unsigned PLAY_MAX_Y = 448;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ENTER,
    ST_MOVE_R,
    ST_DWELL_R,
    ST_MOVE_L,
    ST_DWELL_L,
    ST_TRANSITION,
    ST_DEFEATED
  } boss_state_t;

  typedef enum logic [PHASE_W-1:0] {
    PHASE_0 = 2'd0,
    PHASE_1 = 2'd1,
    PHASE_2 = 2'd2
  } boss_phase_t;

  typedef struct packed {
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
  } boss_pos_t;

  // Phase from remaining health against the two thresholds.
  function automatic boss_phase_t phase_of(input logic [HP_W-1:0] hp,
                                           input logic [HP_W-1:0] p2_hp,
                                           input logic [HP_W-1:0] p3_hp);
    if (hp > p2_hp) return PHASE_0;
    if (hp > p3_hp) return PHASE_1;
    return PHASE_2;
  endfunction

  // Patrol speed in pixels per tick for a given phase.
  function automatic logic [COORD_W-1:0] step_of(input boss_phase_t ph);
    case (ph)
      PHASE_0: return COORD_W'(1);
      PHASE_1: return COORD_W'(2);
      default: return COORD_W'(3);
    endcase
  endfunction

endpackage

// File: rtl/tick_gen.sv
// Game-tick divider: registered strobe high for the one cycle the counter
// sits at TICK_DIV-1.
module tick_gen #(
  parameter int unsigned TICK_DIV = 4000
) (
  input  logic clk_in,
  input  logic reset,
  output logic tick_out
);

  localparam int unsigned CNT_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_d;

  always_comb begin
    cnt_d = (cnt == LAST) ? '0 : cnt + CNT_W'(1);
  end

  // Strobe is registered alongside the counter so it tracks cnt == LAST.
  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      cnt      <= '0;
      tick_out <= 1'b0;
    end else begin
      cnt      <= cnt_d;
      tick_out <= (cnt_d == LAST);
    end
  end

endmodule

// File: rtl/boss_sequencer.sv
// Stage boss encounter controller: entry, patrol, hit/iframe handling,
// health-driven phase transitions and defeat; gates the pattern generator.
module boss_sequencer
  import stg_pkg::*;
#(
  parameter int unsigned TICK_DIV   = 4000,
  parameter int unsigned HOME_X     = 192,
  parameter int unsigned HOME_Y     = 100,
  parameter int unsigned X_MIN      = 64,
  parameter int unsigned X_MAX      = 320,
  parameter int unsigned MAX_HEALTH = 200,
  parameter int unsigned PHASE2_HP  = 120,
  parameter int unsigned PHASE3_HP  = 50,
  parameter int unsigned IFRAMES    = 8,
  parameter int unsigned DWELL      = 64,
  parameter int unsigned TRANS_HOLD = 32
) (
  input  logic               clk_in,
  input  logic               reset,
  input  logic               start,
  input  logic               hit_in,
  output logic [COORD_W-1:0] boss_x,
  output logic [COORD_W-1:0] boss_y,
  output logic [HP_W-1:0]    health,
  output logic [PHASE_W-1:0] phase,
  output logic [PHASE_W-1:0] pattern_sel,
  output logic               fire_en,
  output logic               invuln,
  output logic               defeated,
  output logic               tick_out
);

  localparam int unsigned HOLD_MAX = (DWELL > TRANS_HOLD) ? DWELL : TRANS_HOLD;
  localparam int unsigned HOLD_W   = $clog2(HOLD_MAX + 1);
  localparam int unsigned IFR_W    = $clog2(IFRAMES + 1);

  localparam logic [COORD_W-1:0] HOME_X_C = COORD_W'(HOME_X);
  localparam logic [COORD_W-1:0] HOME_Y_C = COORD_W'(HOME_Y);
  localparam logic [COORD_W-1:0] X_MIN_C  = COORD_W'(X_MIN);
  localparam logic [COORD_W-1:0] X_MAX_C  = COORD_W'(X_MAX);
  localparam logic [COORD_W-1:0] TSTEP_C  = COORD_W'(2);
  localparam logic [HP_W-1:0]    MAX_HP_C = HP_W'(MAX_HEALTH);
  localparam logic [HP_W-1:0]    P2_HP_C  = HP_W'(PHASE2_HP);
  localparam logic [HP_W-1:0]    P3_HP_C  = HP_W'(PHASE3_HP);
  localparam logic [HOLD_W-1:0]  DWELL_LAST = HOLD_W'(DWELL - 1);
  localparam logic [HOLD_W-1:0]  TRANS_LAST = HOLD_W'(TRANS_HOLD - 1);
  localparam logic [IFR_W-1:0]   IFR_LOAD   = IFR_W'(IFRAMES);

  boss_state_t        state, state_d;
  boss_pos_t          pos, pos_d;
  boss_phase_t        phase_q, phase_d;
  logic [HP_W-1:0]    health_q, health_d;
  logic [PHASE_W-1:0] psel_q, psel_d;
  logic               fire_q, fire_d;
  logic               inv_q, inv_d;
  logic               def_q, def_d;
  logic [IFR_W-1:0]   ifr_cnt, ifr_d;
  logic [HOLD_W-1:0]  hold_cnt, hold_d;
  logic               hit_q;

  logic               tick;
  logic               hit_edge;
  logic               fighting;
  logic [COORD_W-1:0] step;
  logic [COORD_W-1:0] x_right, x_left, x_home;

  tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
    .clk_in   (clk_in),
    .reset    (reset),
    .tick_out (tick)
  );

  // Clamped candidate X positions, computed before any register update.
  always_comb begin
    step    = step_of(phase_q);
    x_right = (pos.x >= X_MAX_C - step) ? X_MAX_C : pos.x + step;
    x_left  = (pos.x <= X_MIN_C + step) ? X_MIN_C : pos.x - step;
    x_home  = HOME_X_C;
    if (pos.x < HOME_X_C) begin
      x_home = (pos.x + TSTEP_C >= HOME_X_C) ? HOME_X_C : pos.x + TSTEP_C;
    end else if (pos.x > HOME_X_C) begin
      x_home = (pos.x <= HOME_X_C + TSTEP_C) ? HOME_X_C : pos.x - TSTEP_C;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state;
    pos_d    = pos;
    health_d = health_q;
    psel_d   = psel_q;
    fire_d   = fire_q;
    inv_d    = inv_q;
    def_d    = def_q;
    ifr_d    = ifr_cnt;
    hold_d   = hold_cnt;
    phase_d  = phase_of(health_q, P2_HP_C, P3_HP_C);
    hit_edge = hit_in & ~hit_q;
    fighting = state inside {ST_MOVE_R, ST_DWELL_R, ST_MOVE_L, ST_DWELL_L};

    // An accepted hit reloads the iframe counter, pre-empting that tick's decrement.
    if (fighting) begin
      if (hit_edge && !inv_q) begin
        health_d = (health_q != '0) ? health_q - HP_W'(1) : health_q;
        inv_d    = 1'b1;
        ifr_d    = IFR_LOAD;
      end else if (tick && inv_q) begin
        if (ifr_cnt <= IFR_W'(1)) begin
          inv_d = 1'b0;
          ifr_d = '0;
        end else begin
          ifr_d = ifr_cnt - IFR_W'(1);
        end
      end
    end

    case (state)
      ST_IDLE: begin
        if (start) state_d = ST_ENTER;
      end
      ST_ENTER: begin
        if (tick) begin
          pos_d.y = pos.y + COORD_W'(1);
          if (pos_d.y == HOME_Y_C) begin
            state_d = ST_MOVE_R;
            fire_d  = 1'b1;
            psel_d  = phase_q;
          end
        end
      end
      ST_MOVE_R: begin
        if (tick) begin
          pos_d.x = x_right;
          if (x_right == X_MAX_C) begin
            state_d = ST_DWELL_R;
            hold_d  = '0;
          end
        end
      end
      ST_MOVE_L: begin
        if (tick) begin
          pos_d.x = x_left;
          if (x_left == X_MIN_C) begin
            state_d = ST_DWELL_L;
            hold_d  = '0;
          end
        end
      end
      ST_DWELL_R, ST_DWELL_L: begin
        if (tick) begin
          if (hold_cnt == DWELL_LAST) begin
            state_d = (state == ST_DWELL_R) ? ST_MOVE_L : ST_MOVE_R;
            hold_d  = '0;
          end else begin
            hold_d = hold_cnt + HOLD_W'(1);
          end
        end
      end
      ST_TRANSITION: begin
        // Hold counting only starts once the boss is parked at HOME_X.
        if (tick) begin
          if (pos.x != HOME_X_C) begin
            pos_d.x = x_home;
          end else if (hold_cnt == TRANS_LAST) begin
            state_d = ST_MOVE_R;
            fire_d  = 1'b1;
            psel_d  = phase_q;
            inv_d   = 1'b0;
            ifr_d   = '0;
            hold_d  = '0;
          end else begin
            hold_d = hold_cnt + HOLD_W'(1);
          end
        end
      end
      ST_DEFEATED: begin
        fire_d = 1'b0;
        inv_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase

    // Defeat outranks a phase change seen in the same cycle.
    if (fighting && health_q == '0) begin
      state_d = ST_DEFEATED;
      pos_d   = pos;
      def_d   = 1'b1;
      fire_d  = 1'b0;
      inv_d   = 1'b0;
      ifr_d   = '0;
    end else if (fighting && phase_d > phase_q) begin
      state_d = ST_TRANSITION;
      fire_d  = 1'b0;
      inv_d   = 1'b1;
      ifr_d   = '0;
      hold_d  = '0;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      pos      <= '{x: HOME_X_C, y: '0};
      health_q <= MAX_HP_C;
      phase_q  <= PHASE_0;
      psel_q   <= '0;
      fire_q   <= 1'b0;
      inv_q    <= 1'b0;
      def_q    <= 1'b0;
      ifr_cnt  <= '0;
      hold_cnt <= '0;
      hit_q    <= 1'b0;
    end else begin
      state    <= state_d;
      pos      <= pos_d;
      health_q <= health_d;
      phase_q  <= phase_d;
      psel_q   <= psel_d;
      fire_q   <= fire_d;
      inv_q    <= inv_d;
      def_q    <= def_d;
      ifr_cnt  <= ifr_d;
      hold_cnt <= hold_d;
      hit_q    <= hit_in;
    end
  end

  assign boss_x      = pos.x;
  assign boss_y      = pos.y;
  assign health      = health_q;
  assign phase       = phase_q;
  assign pattern_sel = psel_q;
  assign fire_en     = fire_q;
  assign invuln      = inv_q;
  assign defeated    = def_q;
  assign tick_out    = tick;

endmodule
